// File: rtl/rmii_tx_driver_pkg.sv
// Shared RMII/CRC-32 constants, state encoding and helpers for the RMII transmit path.
// RMII_TX_FCS_EN adds the FCS state; the receive side reuses the CRC constants and step function.
package rmii_tx_driver_pkg;

  localparam logic [1:0]  RMII_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  RMII_SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC32_POLY          = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT          = 32'hFFFFFFFF;
  localparam int          RMII_IPG_DIBITS     = 48;
  localparam int          RMII_FCS_DIBITS     = 16;

`ifdef RMII_TX_FCS_EN
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_FCS, S_IPG} tx_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_IPG} tx_state_t;
`endif

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Reflected CRC-32, bit 0 of the dibit enters first (matches wire order).
  function automatic logic [31:0] crc32_step2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC32_POLY : 32'h0);
    return r;
  endfunction

endpackage

// File: rtl/crc32_2b.sv
// CRC-32 (Ethernet FCS) accumulator, two bits per clock; shared by the TX and RX RMII paths.
module crc32_2b
  import rmii_tx_driver_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || init)
      crc <= CRC32_INIT;
    else if (en)
      crc <= crc32_step2(crc, din);
  end

endmodule

// File: rtl/rmii_tx_driver.sv
// RMII transmitter: frames a dibit stream with preamble/SFD, optional CRC-32 FCS and IPG.
// Define RMII_TX_FCS_EN to append the FCS in hardware; otherwise the caller supplies it.
module rmii_tx_driver
  import rmii_tx_driver_pkg::*;
#(
  parameter int PREAMBLE_DIBITS = 31,
  parameter int IPG_DIBITS      = RMII_IPG_DIBITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       txen,
  output logic [1:0] txd,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int CW = clog2(max3(PREAMBLE_DIBITS, IPG_DIBITS, RMII_FCS_DIBITS) + 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          txen_nxt, busy_nxt, done_nxt, underrun_nxt;
  logic [1:0]    txd_nxt;

  assign in_ready = (state == S_DATA);

`ifdef RMII_TX_FCS_EN
  logic [31:0] crc, fcs;

  // Held in init while idle so every frame starts from a fresh CRC.
  crc32_2b u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (state == S_IDLE),
    .en    (in_valid & in_ready),
    .din   (in),
    .crc   (crc)
  );

  assign fcs = ~crc;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    txen_nxt     = txen;
    txd_nxt      = txd;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    underrun_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          txen_nxt  = 1'b1;
          txd_nxt   = RMII_PREAMBLE_DIBIT;
          busy_nxt  = 1'b1;
          cnt_nxt   = CW'(1);
          state_nxt = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        // cnt = preamble dibits already on the wire.
        if (cnt == CW'(PREAMBLE_DIBITS)) begin
          txd_nxt   = RMII_SFD_DIBIT;
          cnt_nxt   = '0;
          state_nxt = S_DATA;
        end else begin
          txd_nxt = RMII_PREAMBLE_DIBIT;
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (in_valid) begin
          txd_nxt = in;
          if (in_last) begin
            cnt_nxt = '0;
`ifdef RMII_TX_FCS_EN
            state_nxt = S_FCS;
`else
            state_nxt = S_IPG;
`endif
          end
        end else begin
          // Starved mid-payload: cut the frame now, first IPG cycle is this one.
          txen_nxt     = 1'b0;
          txd_nxt      = 2'b00;
          underrun_nxt = 1'b1;
          cnt_nxt      = CW'(1);
          state_nxt    = S_IPG;
        end
      end
`ifdef RMII_TX_FCS_EN
      S_FCS: begin
        txd_nxt = fcs[{cnt[3:0], 1'b0} +: 2];
        if (cnt == CW'(RMII_FCS_DIBITS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_IPG;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      S_IPG: begin
        // Entered with txen still high after a normal frame: drop it and flag done.
        txen_nxt = 1'b0;
        txd_nxt  = 2'b00;
        done_nxt = txen;
        if (txen) begin
          cnt_nxt = CW'(1);
        end else if (cnt == CW'(IPG_DIBITS)) begin
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      txen     <= 1'b0;
      txd      <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      txen     <= txen_nxt;
      txd      <= txd_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      underrun <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_rmii_tx_driver.sv
// Directed bench for rmii_tx_driver: per-cycle trace of the RMII outputs checked against hand-built frames.
module tb_rmii_tx_driver;

`ifdef RMII_TX_FCS_EN
  localparam int FCS_N = 16;
`else
  localparam int FCS_N = 0;
`endif
  localparam int TRN = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in;
  logic       in_valid, in_last;
  logic       in_ready, txen, busy, done, underrun;
  logic [1:0] txd;

  rmii_tx_driver dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .txen     (txen),
    .txd      (txd),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [1:0] tr_d   [TRN];
  bit         tr_en  [TRN];
  bit         tr_busy[TRN];
  bit         tr_done[TRN];
  bit         tr_und [TRN];
  bit         tr_rdy [TRN];
  logic [1:0] q_d[$];
  bit         q_last[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [1:0] d[$]);
    foreach (d[i]) begin
      q_d.push_back(d[i]);
      q_last.push_back(i == d.size() - 1);
    end
  endtask

  // Streams the queued dibits, honouring in_ready; drop_after >= 0 starves the
  // source once that many dibits were accepted. Records outputs each cycle.
  task automatic run(input int ncyc, input int drop_after);
    int         acc;
    bit         dropped, take;
    logic [1:0] tmp_d;
    bit         tmp_l;
    acc = 0;
    dropped = 0;
    for (int k = 0; k < TRN; k++) begin
      tr_d[k] = 2'b00; tr_en[k] = 0; tr_busy[k] = 0;
      tr_done[k] = 0;  tr_und[k] = 0; tr_rdy[k] = 0;
    end
    for (int k = 0; k < ncyc; k++) begin
      if (drop_after >= 0 && acc == drop_after) dropped = 1;
      in_valid = (q_d.size() > 0) && !dropped;
      in       = in_valid ? q_d[0] : 2'b00;
      in_last  = in_valid ? q_last[0] : 1'b0;
      take     = in_valid && in_ready;
      @(posedge clk);
      if (take) begin
        tmp_d = q_d.pop_front();
        tmp_l = q_last.pop_front();
        acc++;
      end
      #1;
      tr_d[k] = txd;   tr_en[k] = txen;   tr_busy[k] = busy;
      tr_done[k] = done; tr_und[k] = underrun; tr_rdy[k] = in_ready;
    end
    in_valid = 0; in_last = 0; in = 2'b00;
    q_d.delete();
    q_last.delete();
  endtask

  function automatic int find_en(input int from, input bit val);
    for (int k = (from < 0 ? 0 : from); k < TRN; k++)
      if (tr_en[k] == val) return k;
    return -1;
  endfunction

  function automatic int find_busy_low(input int from);
    for (int k = (from < 0 ? 0 : from); k < TRN; k++)
      if (!tr_busy[k]) return k;
    return -1;
  endfunction

  function automatic int ci(input int k);
    return (k < 0) ? 0 : (k >= TRN ? TRN - 1 : k);
  endfunction

  function automatic int cnt_done();
    int n = 0;
    for (int k = 0; k < TRN; k++) n += int'(tr_done[k]);
    return n;
  endfunction

  function automatic int cnt_und();
    int n = 0;
    for (int k = 0; k < TRN; k++) n += int'(tr_und[k]);
    return n;
  endfunction

  // Mismatching dibits among 31x preamble at trace index r.
  function automatic int bad_preamble(input int r);
    int n = 0;
    for (int i = 0; i < 31; i++) if (tr_d[ci(r + i)] !== 2'b01) n++;
    return n;
  endfunction

  initial begin
    logic [1:0] f2[$];
    logic [1:0] pay[$];
    logic [7:0]  by;
    logic [31:0] fv;
    int r, f, b, r2, f2i, n, bad;

    reset = 1; in = 2'b00; in_valid = 0; in_last = 0;
    repeat (3) step();
    chk("rst_txen", txen, 0);
    chk("rst_txd", txd, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_und", {done, underrun}, 0);
    reset = 0;

    // 1: idle forever
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (txen || busy || in_ready || done || underrun) bad++;
    end
    chk("t1_idle_quiet", bad, 0);

    // 2: 4-dibit frame 10,01,11,00
    f2 = '{2'b10, 2'b01, 2'b11, 2'b00};
    push_frame(f2);
    run(160, -1);
    r = find_en(0, 1);
    f = find_en(r, 0);
    chk("t2_rise", r, 0);
    chk("t2_len", f - r, 36 + FCS_N);
    chk("t2_preamble", bad_preamble(r), 0);
    chk("t2_sfd", tr_d[ci(r + 31)], 3);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_pay%0d", i), tr_d[ci(r + 32 + i)], f2[i]);
    chk("t2_txd_fall", tr_d[ci(f)], 0);
    chk("t2_done_at_fall", tr_done[ci(f)], 1);
    chk("t2_done_cnt", cnt_done(), 1);
    chk("t2_und_cnt", cnt_und(), 0);
    b = find_busy_low(f);
    chk("t2_busy_ipg", b - f, 48);
    chk("t2_rdy_preamble", tr_rdy[ci(r + 30)], 0);

`ifdef RMII_TX_FCS_EN
    // 3: "123456789" -> FCS 0xCBF43926 appended LSB-first
    pay = {};
    for (int j = 0; j < 9; j++) begin
      by = 8'h31 + 8'(j);
      for (int d = 0; d < 4; d++) pay.push_back(by[2*d +: 2]);
    end
    push_frame(pay);
    run(170, -1);
    r = find_en(0, 1);
    f = find_en(r, 0);
    chk("t3_len", f - r, 32 + 36 + 16);
    chk("t3_fcs0", tr_d[ci(r + 68)], 2);
    fv = 32'hCBF43926;
    bad = 0;
    for (int j = 0; j < 16; j++) if (tr_d[ci(r + 68 + j)] !== fv[2*j +: 2]) bad++;
    chk("t3_fcs_dibits", bad, 0);
    chk("t3_done_at_fall", tr_done[ci(f)], 1);
    chk("t3_done_cnt", cnt_done(), 1);
`endif

    // 4: underrun after 5th payload dibit
    pay = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
    push_frame(pay);
    run(150, 5);
    r = find_en(0, 1);
    f = find_en(r, 0);
    chk("t4_len", f - r, 37);
    chk("t4_last_pay", tr_d[ci(f - 1)], 3);
    chk("t4_txd_fall", tr_d[ci(f)], 0);
    chk("t4_und_at_fall", tr_und[ci(f)], 1);
    chk("t4_und_cnt", cnt_und(), 1);
    chk("t4_done_cnt", cnt_done(), 0);
    b = find_busy_low(f);
    chk("t4_busy_ipg", b - f, 48);

    // 5: back-to-back frames, in_valid held high through IPG
    push_frame(f2);
    pay = '{2'b00, 2'b11, 2'b01, 2'b10};
    push_frame(pay);
    run(230, -1);
    r   = find_en(0, 1);
    f   = find_en(r, 0);
    r2  = find_en(f, 1);
    f2i = find_en(r2, 0);
    chk("t5_gap", r2 - f, 49);
    n = 0;
    for (int k = ci(f); k <= ci(r2 + 30); k++) n += int'(tr_rdy[k]);
    chk("t5_rdy_ipg_pre", n, 0);
    chk("t5_len2", f2i - r2, 36 + FCS_N);
    chk("t5_pay2_0", tr_d[ci(r2 + 32)], 0);
    chk("t5_done_cnt", cnt_done(), 2);

    // 6: reset during DATA
    pay = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
    push_frame(pay);
    run(34, -1);
    chk("t6_in_data", in_ready, 1);
    reset = 1;
    step();
    chk("t6_txen", txen, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done_und", {done, underrun}, 0);
    reset = 0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      n += int'(done) + int'(underrun) + int'(txen);
    end
    chk("t6_quiet_after", n, 0);
    push_frame(f2);
    run(160, -1);
    r = find_en(0, 1);
    f = find_en(r, 0);
    chk("t6_fresh_len", f - r, 36 + FCS_N);
    chk("t6_fresh_done", cnt_done(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
